// File: rtl/retire_rat_pkg.sv
// Shared types and constants for the retirement RAT.
// Holds the PRF/ARF index widths, the zero-register index, the retirement
// slot payload and the recover FSM state encodings.
package retire_rat_pkg;

    localparam int unsigned PRF_W    = 6;   // physical register tag width
    localparam int unsigned ARF_N    = 32;  // number of architectural registers
    localparam int unsigned ARF_W    = 5;   // architectural index width
    localparam int unsigned ZERO_REG = 31;  // hard-wired zero, never renamed

    typedef logic [PRF_W-1:0] prf_idx_t;
    typedef logic [ARF_W-1:0] arf_idx_t;

    localparam arf_idx_t ZERO_IDX = ARF_W'(ZERO_REG);

    // One retiring instruction as presented by the reorder buffer.
    typedef struct packed {
        logic     valid;
        arf_idx_t adest;
        prf_idx_t pdest;
    } ret_slot_t;

    // Recover pulse FSM.
    typedef enum logic {
        IDLE    = 1'b0,
        RECOVER = 1'b1
    } rec_state_e;

endpackage

// File: rtl/retire_rat_bypass.sv
// rat_bypass: combinational two-slot lookup into the committed map.
// Produces the superseded tags (old1_c/old2_c), the map write enables and
// the free strobes for both retirement slots. Slot 2 sees slot 1's write
// (same-adest forward); a zero-register destination frees its own pdest.
// Ports:
//   map      committed map, entry i = map[i]
//   slot1    older retirement, slot2 younger retirement
//   wr1_c/wr2_c      map write enables
//   free1_c/free2_c  free strobes for the following cycle
//   old1_c/old2_c    tags to return to the free list
module rat_bypass
    import retire_rat_pkg::*;
(
    input  logic [ARF_N-1:0][PRF_W-1:0] map,
    input  ret_slot_t                   slot1,
    input  ret_slot_t                   slot2,
    output logic                        wr1_c,
    output logic                        wr2_c,
    output logic                        free1_c,
    output logic                        free2_c,
    output prf_idx_t                    old1_c,
    output prf_idx_t                    old2_c
);

    always_comb begin
        wr1_c   = 1'b0;
        wr2_c   = 1'b0;
        free1_c = 1'b0;
        free2_c = 1'b0;
        old1_c  = '0;
        old2_c  = '0;

        free1_c = slot1.valid;
        wr1_c   = slot1.valid && (slot1.adest != ZERO_IDX);
        old1_c  = wr1_c ? map[slot1.adest] : slot1.pdest;

        // Slot 2 only counts when the older slot also retires.
        free2_c = slot2.valid && slot1.valid;
        wr2_c   = free2_c && (slot2.adest != ZERO_IDX);
        if (slot2.adest == ZERO_IDX) begin
            old2_c = slot2.pdest;
        end else if (wr1_c && (slot2.adest == slot1.adest)) begin
            old2_c = slot1.pdest;
        end else begin
            old2_c = map[slot2.adest];
        end
    end

endmodule

// File: rtl/retire_rat.sv
// retire_rat: retirement register alias table downstream of the ROB.
// Applies up to two retirements per cycle to the committed arch->PRF map,
// returns superseded tags to the free list one cycle later, and pulses
// recover the cycle after a branch miss so the front-end RAT can copy map_out.
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   ret1_*/ret2_*           retirement slots (slot 2 legal only with slot 1)
//   branch_miss             mispredict detected at retirement
//   free1_*/free2_*         registered freed-tag strobes and tags
//   recover                 one-cycle pulse after branch_miss
//   map_out                 committed map, entry i at [i*PRF_W +: PRF_W]
//   retired_cnt             retired-instruction count
// Config macro: RETIRE_RAT_INSTRET_EN enables the retired_cnt counter;
// otherwise retired_cnt is tied to zero.
module retire_rat
    import retire_rat_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     ret1_valid,
    input  logic                     ret2_valid,
    input  logic [ARF_W-1:0]         ret1_adest,
    input  logic [ARF_W-1:0]         ret2_adest,
    input  logic [PRF_W-1:0]         ret1_pdest,
    input  logic [PRF_W-1:0]         ret2_pdest,
    input  logic                     branch_miss,
    output logic                     free1_valid,
    output logic                     free2_valid,
    output logic [PRF_W-1:0]         free1_tag,
    output logic [PRF_W-1:0]         free2_tag,
    output logic                     recover,
    output logic [ARF_N*PRF_W-1:0]   map_out,
    output logic [63:0]              retired_cnt
);

    logic [ARF_N-1:0][PRF_W-1:0] map_q;
    ret_slot_t  slot1, slot2;
    logic       wr1_c, wr2_c, free1_c, free2_c;
    prf_idx_t   old1_c, old2_c;
    rec_state_e state_q, state_d;

    assign slot1 = '{valid: ret1_valid, adest: ret1_adest, pdest: ret1_pdest};
    assign slot2 = '{valid: ret2_valid, adest: ret2_adest, pdest: ret2_pdest};

    rat_bypass u_bypass (
        .map     (map_q),
        .slot1   (slot1),
        .slot2   (slot2),
        .wr1_c   (wr1_c),
        .wr2_c   (wr2_c),
        .free1_c (free1_c),
        .free2_c (free2_c),
        .old1_c  (old1_c),
        .old2_c  (old2_c)
    );

    // Committed map; slot 2's write is issued last so the younger write wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < ARF_N; i++) begin
                map_q[i] <= PRF_W'(i);
            end
        end else begin
            if (wr1_c) map_q[ret1_adest] <= ret1_pdest;
            if (wr2_c) map_q[ret2_adest] <= ret2_pdest;
        end
    end

    assign map_out = map_q;

    // Free-list return flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            free1_valid <= 1'b0;
            free2_valid <= 1'b0;
            free1_tag   <= '0;
            free2_tag   <= '0;
        end else begin
            free1_valid <= free1_c;
            free2_valid <= free2_c;
            free1_tag   <= free1_c ? old1_c : '0;
            free2_tag   <= free2_c ? old2_c : '0;
        end
    end

    // Recover FSM state register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Recover FSM next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (branch_miss) state_d = RECOVER;
            RECOVER: state_d = branch_miss ? RECOVER : IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign recover = (state_q == RECOVER);

`ifdef RETIRE_RAT_INSTRET_EN
    logic [63:0] retired_cnt_q;

    // Counts effective retirements; an orphan slot 2 is dropped and not counted.
    always_ff @(posedge clk) begin
        if (reset) retired_cnt_q <= '0;
        else       retired_cnt_q <= retired_cnt_q + 64'(free1_c) + 64'(free2_c);
    end

    assign retired_cnt = retired_cnt_q;
`else
    assign retired_cnt = '0;
`endif

    a_slot2_needs_slot1: assert property (@(posedge clk) disable iff (reset)
        !(ret2_valid && !ret1_valid))
        else $warning("retire_rat: ret2_valid without ret1_valid, slot 2 ignored");

endmodule

// File: tb/tb_retire_rat.sv
module tb_retire_rat;

    logic        clk = 1'b0;
    logic        reset;
    logic        ret1_valid, ret2_valid;
    logic [4:0]  ret1_adest, ret2_adest;
    logic [5:0]  ret1_pdest, ret2_pdest;
    logic        branch_miss;
    logic        free1_valid, free2_valid;
    logic [5:0]  free1_tag, free2_tag;
    logic        recover;
    logic [191:0] map_out;
    logic [63:0] retired_cnt;

    always #5 clk = ~clk;

    retire_rat dut (
        .clk         (clk),
        .reset       (reset),
        .ret1_valid  (ret1_valid),
        .ret2_valid  (ret2_valid),
        .ret1_adest  (ret1_adest),
        .ret2_adest  (ret2_adest),
        .ret1_pdest  (ret1_pdest),
        .ret2_pdest  (ret2_pdest),
        .branch_miss (branch_miss),
        .free1_valid (free1_valid),
        .free2_valid (free2_valid),
        .free1_tag   (free1_tag),
        .free2_tag   (free2_tag),
        .recover     (recover),
        .map_out     (map_out),
        .retired_cnt (retired_cnt)
    );

    typedef struct {
        logic       v1;
        logic [5:0] t1;
        logic       v2;
        logic [5:0] t2;
        logic       rec;
    } exp_t;

    typedef struct {
        bit v1; int a1; int p1;
        bit v2; int a2; int p2;
        bit bm;
    } stim_t;

    exp_t            sbq[$];
    int              mdl_map[32];
    longint unsigned mdl_cnt;
    int              vectors = 0;
    int              miscompares = 0;

    function automatic longint unsigned exp_cnt();
`ifdef RETIRE_RAT_INSTRET_EN
        return mdl_cnt;
`else
        return 64'd0;
`endif
    endfunction

    task automatic clear_inputs();
        ret1_valid = 0; ret2_valid = 0; branch_miss = 0;
        ret1_adest = 0; ret2_adest = 0; ret1_pdest = 0; ret2_pdest = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1;
        repeat (2) @(posedge clk);
        #1 reset = 0;
        for (int i = 0; i < 32; i++) mdl_map[i] = i;
        mdl_cnt = 0;
        sbq.delete();
    endtask

    // Drive one retirement cycle, update the reference model and queue the
    // free/recover outputs expected after the edge.
    task automatic step(input stim_t s);
        exp_t e;
        ret1_valid = s.v1; ret1_adest = 5'(s.a1); ret1_pdest = 6'(s.p1);
        ret2_valid = s.v2; ret2_adest = 5'(s.a2); ret2_pdest = 6'(s.p2);
        branch_miss = s.bm;
        e.v1 = s.v1; e.t1 = 0; e.v2 = 0; e.t2 = 0; e.rec = s.bm;
        if (s.v1) begin
            if (s.a1 == 31) e.t1 = 6'(s.p1);
            else begin e.t1 = 6'(mdl_map[s.a1]); mdl_map[s.a1] = s.p1; end
        end
        if (s.v1 && s.v2) begin
            e.v2 = 1;
            if (s.a2 == 31) e.t2 = 6'(s.p2);
            else begin e.t2 = 6'(mdl_map[s.a2]); mdl_map[s.a2] = s.p2; end
        end
        mdl_cnt += longint'(s.v1) + longint'(s.v1 && s.v2);
        sbq.push_back(e);
        @(posedge clk);
        #1 clear_inputs();
    endtask

    task automatic test_reset();
        int bad;
        vectors++;
        if (free1_valid !== 0 || free2_valid !== 0 || free1_tag !== 0 || free2_tag !== 0) begin
            miscompares++;
            $display("FAIL reset_free: got v=%b%b t=%0d/%0d, need all zero",
                     free1_valid, free2_valid, free1_tag, free2_tag);
        end
        vectors++;
        if (recover !== 0 || retired_cnt !== 0) begin
            miscompares++;
            $display("FAIL reset_rec_cnt: got recover=%b cnt=%0d, need 0/0", recover, retired_cnt);
        end
        bad = -1;
        for (int i = 0; i < 32; i++) if (map_out[i*6 +: 6] !== 6'(i)) bad = i;
        vectors++;
        if (bad >= 0) begin
            miscompares++;
            $display("FAIL reset_map: entry %0d got %0d, need %0d", bad, map_out[bad*6 +: 6], bad);
        end
    endtask

    task automatic test_basic();
        stim_t tbl[4];
        exp_t  e;
        int    bad;
        tbl[0] = '{1, 3, 40, 0, 0, 0, 0};
        tbl[1] = '{1, 5, 41, 1, 5, 42, 0};
        tbl[2] = '{1, 31, 50, 0, 0, 0, 0};
        tbl[3] = '{1, 31, 51, 1, 31, 52, 0};
        foreach (tbl[k]) begin
            step(tbl[k]);
            e = sbq.pop_front();
            vectors++;
            if (free1_valid !== e.v1 || (e.v1 && free1_tag !== e.t1) ||
                free2_valid !== e.v2 || (e.v2 && free2_tag !== e.t2) || recover !== e.rec) begin
                miscompares++;
                $display("FAIL basic[%0d]: got v=%b%b t=%0d/%0d rec=%b, need v=%b%b t=%0d/%0d rec=%b",
                         k, free1_valid, free2_valid, free1_tag, free2_tag, recover,
                         e.v1, e.v2, e.t1, e.t2, e.rec);
            end
            bad = -1;
            for (int i = 0; i < 32; i++) if (map_out[i*6 +: 6] !== 6'(mdl_map[i])) bad = i;
            vectors++;
            if (bad >= 0) begin
                miscompares++;
                $display("FAIL basic_map[%0d]: entry %0d got %0d, need %0d",
                         k, bad, map_out[bad*6 +: 6], mdl_map[bad]);
            end
        end
        // Hand-derived values for the directed cases.
        vectors++;
        if (map_out[3*6 +: 6] !== 6'd40 || map_out[5*6 +: 6] !== 6'd42 || map_out[31*6 +: 6] !== 6'd31) begin
            miscompares++;
            $display("FAIL basic_entries: got m3=%0d m5=%0d m31=%0d, need 40/42/31",
                     map_out[3*6 +: 6], map_out[5*6 +: 6], map_out[31*6 +: 6]);
        end
    endtask

    task automatic test_branch_miss();
        stim_t tbl[5];
        exp_t  e;
        int    bad;
        tbl[0] = '{1, 7, 60, 0, 0, 0, 1};
        tbl[1] = '{0, 0, 0, 0, 0, 0, 0};
        tbl[2] = '{1, 8, 61, 1, 9, 62, 1};
        tbl[3] = '{0, 0, 0, 0, 0, 0, 1};
        tbl[4] = '{0, 0, 0, 0, 0, 0, 0};
        foreach (tbl[k]) begin
            step(tbl[k]);
            e = sbq.pop_front();
            vectors++;
            if (free1_valid !== e.v1 || (e.v1 && free1_tag !== e.t1) ||
                free2_valid !== e.v2 || (e.v2 && free2_tag !== e.t2) || recover !== e.rec) begin
                miscompares++;
                $display("FAIL bmiss[%0d]: got v=%b%b t=%0d/%0d rec=%b, need v=%b%b t=%0d/%0d rec=%b",
                         k, free1_valid, free2_valid, free1_tag, free2_tag, recover,
                         e.v1, e.v2, e.t1, e.t2, e.rec);
            end
            bad = -1;
            for (int i = 0; i < 32; i++) if (map_out[i*6 +: 6] !== 6'(mdl_map[i])) bad = i;
            vectors++;
            if (bad >= 0) begin
                miscompares++;
                $display("FAIL bmiss_map[%0d]: entry %0d got %0d, need %0d",
                         k, bad, map_out[bad*6 +: 6], mdl_map[bad]);
            end
            if (k == 0) begin
                vectors++;
                if (recover !== 1'b1 || map_out[7*6 +: 6] !== 6'd60) begin
                    miscompares++;
                    $display("FAIL bmiss_pulse: got rec=%b m7=%0d, need 1/60", recover, map_out[7*6 +: 6]);
                end
            end
        end
    endtask

    task automatic test_illegal_slot2();
        stim_t s;
        exp_t  e;
        int    bad;
        s = '{0, 0, 0, 1, 9, 33, 0};
        step(s);
        e = sbq.pop_front();
        vectors++;
        if (free1_valid !== e.v1 || free2_valid !== e.v2 || recover !== e.rec) begin
            miscompares++;
            $display("FAIL illegal_free: got v=%b%b rec=%b, need v=%b%b rec=%b",
                     free1_valid, free2_valid, recover, e.v1, e.v2, e.rec);
        end
        bad = -1;
        for (int i = 0; i < 32; i++) if (map_out[i*6 +: 6] !== 6'(mdl_map[i])) bad = i;
        vectors++;
        if (bad >= 0) begin
            miscompares++;
            $display("FAIL illegal_map: entry %0d got %0d, need %0d", bad, map_out[bad*6 +: 6], mdl_map[bad]);
        end
    endtask

    task automatic test_instret_and_reset();
        stim_t tbl[4];
        exp_t  e;
        int    bad;
        do_reset();
        tbl[0] = '{1, 1, 33, 1, 2, 34, 0};
        tbl[1] = '{1, 3, 35, 1, 4, 36, 0};
        tbl[2] = '{1, 5, 37, 1, 31, 38, 0};
        tbl[3] = '{1, 6, 39, 0, 0, 0, 0};
        foreach (tbl[k]) begin
            step(tbl[k]);
            e = sbq.pop_front();
            vectors++;
            if (free1_valid !== e.v1 || (e.v1 && free1_tag !== e.t1) ||
                free2_valid !== e.v2 || (e.v2 && free2_tag !== e.t2) || recover !== e.rec) begin
                miscompares++;
                $display("FAIL instret[%0d]: got v=%b%b t=%0d/%0d rec=%b, need v=%b%b t=%0d/%0d rec=%b",
                         k, free1_valid, free2_valid, free1_tag, free2_tag, recover,
                         e.v1, e.v2, e.t1, e.t2, e.rec);
            end
        end
        vectors++;
`ifdef RETIRE_RAT_INSTRET_EN
        if (retired_cnt !== 64'd7) begin
            miscompares++;
            $display("FAIL instret_cnt: got %0d, need 7", retired_cnt);
        end
`else
        if (retired_cnt !== 64'd0) begin
            miscompares++;
            $display("FAIL instret_cnt: got %0d, need 0", retired_cnt);
        end
`endif
        // Reset lands on the same edge as a retirement with a branch miss.
        ret1_valid = 1; ret1_adest = 5'd10; ret1_pdest = 6'd44; branch_miss = 1;
        reset = 1;
        @(posedge clk);
        #1 clear_inputs();
        reset = 0;
        for (int i = 0; i < 32; i++) mdl_map[i] = i;
        mdl_cnt = 0;
        for (int c = 0; c < 2; c++) begin
            vectors++;
            if (free1_valid !== 0 || free2_valid !== 0 || recover !== 0 || retired_cnt !== exp_cnt()) begin
                miscompares++;
                $display("FAIL midreset[%0d]: got v=%b%b rec=%b cnt=%0d, need 0/0/0/%0d",
                         c, free1_valid, free2_valid, recover, retired_cnt, exp_cnt());
            end
            bad = -1;
            for (int i = 0; i < 32; i++) if (map_out[i*6 +: 6] !== 6'(i)) bad = i;
            vectors++;
            if (bad >= 0) begin
                miscompares++;
                $display("FAIL midreset_map[%0d]: entry %0d got %0d, need %0d", c, bad, map_out[bad*6 +: 6], bad);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_random();
        stim_t s;
        exp_t  e;
        int    bad;
        for (int k = 0; k < 300; k++) begin
            s.v1 = 1'($urandom_range(0, 3) != 0);
            s.v2 = s.v1 && ($urandom_range(0, 1) == 1);
            s.a1 = $urandom_range(0, 31);
            s.a2 = ($urandom_range(0, 3) == 0) ? s.a1 : int'($urandom_range(0, 31));
            s.p1 = $urandom_range(0, 63);
            s.p2 = $urandom_range(0, 63);
            s.bm = ($urandom_range(0, 4) == 0);
            step(s);
            e = sbq.pop_front();
            vectors++;
            if (free1_valid !== e.v1 || (e.v1 && free1_tag !== e.t1) ||
                free2_valid !== e.v2 || (e.v2 && free2_tag !== e.t2) || recover !== e.rec) begin
                miscompares++;
                $display("FAIL random[%0d]: got v=%b%b t=%0d/%0d rec=%b, need v=%b%b t=%0d/%0d rec=%b",
                         k, free1_valid, free2_valid, free1_tag, free2_tag, recover,
                         e.v1, e.v2, e.t1, e.t2, e.rec);
            end
            bad = -1;
            for (int i = 0; i < 32; i++) if (map_out[i*6 +: 6] !== 6'(mdl_map[i])) bad = i;
            vectors++;
            if (bad >= 0) begin
                miscompares++;
                $display("FAIL random_map[%0d]: entry %0d got %0d, need %0d",
                         k, bad, map_out[bad*6 +: 6], mdl_map[bad]);
            end
        end
        vectors++;
        if (retired_cnt !== exp_cnt()) begin
            miscompares++;
            $display("FAIL random_cnt: got %0d, need %0d", retired_cnt, exp_cnt());
        end
    endtask

    initial begin
        do_reset();
        test_reset();
        test_basic();
        test_branch_miss();
        test_illegal_slot2();
        test_instret_and_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
